// File: rtl/veerwolf_wb_initiator.sv
// Single-outstanding Wishbone classic initiator.
// Takes one command over a valid/ready handshake, runs one cyc/stb cycle,
// and presents the result on a held response port. A transaction that gets
// no ack/err within TIMEOUT_CYCLES bus cycles is closed with an error.
module veerwolf_wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // command port
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [31:0] i_cmd_dat,
    input  logic [3:0]  i_cmd_sel,
    // response port
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_dat,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    // wishbone initiator
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_busy
);

    // Counter is at least 8 bits, grows to fit TIMEOUT_CYCLES, capped at 32.
    localparam int unsigned CW_RAW = $clog2(64'(TIMEOUT_CYCLES) + 64'd1);
    localparam int unsigned CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] to_cnt;
    logic          to_hit;

    // Timeout fires on the last allowed bus cycle; a zero limit never fires.
    assign to_hit      = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
    assign o_cmd_ready = (state == IDLE) && i_rst_n;
    assign o_rsp_valid = (state == RSP);
    assign o_busy      = (state != IDLE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: accept -> bus cycle -> held response -> idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_cmd_valid) state_nxt = BUS;
            BUS:     if (i_wb_ack || i_wb_err || to_hit) state_nxt = RSP;
            RSP:     if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wishbone request registers, timeout counter and response capture.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wb_adr      <= '0;
            o_wb_dat      <= '0;
            o_wb_sel      <= '0;
            o_wb_we       <= 1'b0;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_rsp_dat     <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
            to_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        o_wb_adr <= i_cmd_adr;
                        o_wb_dat <= i_cmd_dat;
                        o_wb_sel <= i_cmd_sel;
                        o_wb_we  <= i_cmd_we;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        to_cnt   <= '0;
                    end
                end
                BUS: begin
                    // err beats ack; either beats the timeout
                    if (i_wb_err) begin
                        o_rsp_dat     <= '0;
                        o_rsp_err     <= 1'b1;
                        o_rsp_timeout <= 1'b0;
                        o_wb_cyc      <= 1'b0;
                        o_wb_stb      <= 1'b0;
                    end else if (i_wb_ack) begin
                        o_rsp_dat     <= o_wb_we ? 32'h0 : i_wb_rdt;
                        o_rsp_err     <= 1'b0;
                        o_rsp_timeout <= 1'b0;
                        o_wb_cyc      <= 1'b0;
                        o_wb_stb      <= 1'b0;
                    end else if (to_hit) begin
                        o_rsp_dat     <= '0;
                        o_rsp_err     <= 1'b1;
                        o_rsp_timeout <= 1'b1;
                        o_wb_cyc      <= 1'b0;
                        o_wb_stb      <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                default: ; // RSP: response held until taken
            endcase
        end
    end

endmodule

// File: tb/tb_veerwolf_wb_initiator.sv
// Directed bench for veerwolf_wb_initiator (TIMEOUT_CYCLES = 4).
// Inputs change and outputs are sampled on the falling edge.
module tb_veerwolf_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_dat;
    logic [31:0] wb_adr, wb_dat, wb_rdt;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, busy;

    int checks = 0;
    int errors = 0;

    veerwolf_wb_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_dat(rsp_dat),
        .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .i_wb_rdt(wb_rdt),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; returns at the negedge of BUS cycle 1.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Terminate in BUS cycle n; returns at the negedge of the first RSP cycle.
    task automatic term(input int n, input logic a, input logic e, input logic [31:0] rdt);
        repeat (n - 1) @(negedge clk);
        wb_ack = a; wb_err = e; wb_rdt = rdt;
        @(negedge clk);
        wb_ack = 1'b0; wb_err = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] held;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; wb_rdt = '0; wb_ack = 1'b0; wb_err = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_cyc", wb_cyc, 1'b0);
        chk1("rst_stb", wb_stb, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_wb_adr", wb_adr, 32'h0);
        chk32("rst_rsp_dat", rsp_dat, 32'h0);
        rst_n = 1'b1;
        #1 chk1("rel_cmd_ready", cmd_ready, 1'b1);

        // ack/err outside BUS are ignored
        @(negedge clk);
        wb_ack = 1'b1; wb_err = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0; wb_err = 1'b0;
        chk1("idle_ack_ignored", rsp_valid, 1'b0);
        chk1("idle_ack_busy", busy, 1'b0);

        // read with 1-cycle responder
        issue(1'b0, 32'h8000_1000, 32'h0, 4'hF);
        chk1("rd_cyc", wb_cyc, 1'b1);
        chk1("rd_stb", wb_stb, 1'b1);
        chk1("rd_we", wb_we, 1'b0);
        chk32("rd_adr", wb_adr, 32'h8000_1000);
        chk1("rd_cmd_ready", cmd_ready, 1'b0);
        chk1("rd_busy", busy, 1'b1);
        term(2, 1'b1, 1'b0, 32'h0102_0304);
        chk1("rd_rsp_valid", rsp_valid, 1'b1);
        chk1("rd_cyc_low", wb_cyc, 1'b0);
        chk32("rd_rsp_dat", rsp_dat, 32'h0102_0304);
        chk1("rd_rsp_err", rsp_err, 1'b0);
        take_rsp();
        chk1("rd_done_valid", rsp_valid, 1'b0);
        chk1("rd_done_ready", cmd_ready, 1'b1);

        // write held stable until ack
        issue(1'b1, 32'h8000_103C, 32'hDEAD_BEEF, 4'h3);
        chk1("wr_we", wb_we, 1'b1);
        chk32("wr_sel", {28'h0, wb_sel}, 32'h3);
        chk32("wr_dat", wb_dat, 32'hDEAD_BEEF);
        @(negedge clk);
        chk32("wr_dat_hold", wb_dat, 32'hDEAD_BEEF);
        chk32("wr_adr_hold", wb_adr, 32'h8000_103C);
        chk1("wr_cyc_hold", wb_cyc, 1'b1);
        term(2, 1'b1, 1'b0, 32'h5555_5555);
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk32("wr_rsp_dat", rsp_dat, 32'h0);
        chk1("wr_rsp_err", rsp_err, 1'b0);
        take_rsp();

        // timeout: cyc high exactly 4 cycles
        issue(1'b0, 32'h8000_2000, 32'h0, 4'hF);
        n = 0;
        while (wb_cyc && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk32("to_cyc_cycles", 32'(n), 32'd4);
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk1("to_rsp_err", rsp_err, 1'b1);
        chk1("to_rsp_timeout", rsp_timeout, 1'b1);
        chk32("to_rsp_dat", rsp_dat, 32'h0);
        take_rsp();

        // ack in the 4th cycle beats the timeout
        issue(1'b0, 32'h8000_2004, 32'h0, 4'hF);
        term(4, 1'b1, 1'b0, 32'hA5A5_A5A5);
        chk1("ack4_rsp_valid", rsp_valid, 1'b1);
        chk1("ack4_err", rsp_err, 1'b0);
        chk1("ack4_timeout", rsp_timeout, 1'b0);
        chk32("ack4_dat", rsp_dat, 32'hA5A5_A5A5);
        take_rsp();

        // ack and err together: err wins
        issue(1'b0, 32'h8000_2008, 32'h0, 4'hF);
        term(2, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk1("ae_err", rsp_err, 1'b1);
        chk1("ae_timeout", rsp_timeout, 1'b0);
        chk32("ae_dat", rsp_dat, 32'h0);
        take_rsp();

        // back-pressured response with a waiting command
        issue(1'b0, 32'h8000_3000, 32'h0, 4'hF);
        term(2, 1'b1, 1'b0, 32'h1234_5678);
        held = 32'h1234_5678;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h8000_4000;
        cmd_dat = 32'hCAFE_0001; cmd_sel = 4'hF;
        for (int i = 0; i < 10; i++) begin
            chk1("bp_valid", rsp_valid, 1'b1);
            chk32("bp_dat", rsp_dat, held);
            chk1("bp_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("bp_idle_ready", cmd_ready, 1'b1);
        chk1("bp_no_accept", wb_cyc, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("bp_next_cyc", wb_cyc, 1'b1);
        chk32("bp_next_adr", wb_adr, 32'h8000_4000);
        chk1("bp_next_we", wb_we, 1'b1);
        term(2, 1'b1, 1'b0, 32'h0);
        take_rsp();

        // reset in the 2nd BUS cycle
        issue(1'b0, 32'h8000_5000, 32'h0, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("mr_cyc", wb_cyc, 1'b0);
        chk1("mr_stb", wb_stb, 1'b0);
        chk1("mr_rsp_valid", rsp_valid, 1'b0);
        chk1("mr_cmd_ready", cmd_ready, 1'b0);
        rst_n = 1'b1;
        #1 chk1("mr_rel_ready", cmd_ready, 1'b1);
        @(negedge clk);
        chk1("mr_after_valid", rsp_valid, 1'b0);
        chk1("mr_after_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
